// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared types for the interval-timer controller:
//   - DEF_WIDTH / DEF_PS_W : default count/limit and prescale widths
//   - state_e              : controller state encoding (2-bit)
//   - cfg_t                : configuration bundle at the default widths
package counter_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_PS_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] limit;
        logic [DEF_PS_W-1:0]  prescale;
        logic                 autoreload;
    } cfg_t;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler
//   Divides enabled cycles by (div+1): tick is high on the enabled cycle in
//   which the prescaler sits at div, and the prescaler then returns to 0.
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous active-high reset
//     clr   in   synchronous clear of the prescaler (start/abort)
//     en    in   advance the prescaler this cycle
//     div   in   divider value P
//     tick  out  combinational terminal-tick strobe
module counter_prescaler
    import counter_ctrl_pkg::*;
#(
    parameter int PS_W = DEF_PS_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [PS_W-1:0] div,
    output logic            tick
);

    logic [PS_W-1:0] r_ps;
    logic            w_at_div;

    assign w_at_div = (r_ps == div);
    assign tick     = en && w_at_div;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ps <= '0;
        end else if (en) begin
            r_ps <= w_at_div ? '0 : r_ps + 1'b1;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Programmable interval-timer controller. Latches a configuration
//   (limit L, prescale P, one-shot/auto-reload), runs the event counter on
//   start, freezes it on pause, cancels on abort and flags terminal count
//   with a one-cycle done pulse plus a sticky irq.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     cfg_valid / cfg_ready        configuration handshake (ready in IDLE/DONE)
//     cfg_limit / cfg_prescale     terminal count L, divider P
//     cfg_autoreload               1 = periodic, 0 = one-shot
//     start, abort, irq_clr        control pulses
//     pause                        level; freezes the run while high
//     count                        registered current count
//     busy                         registered, high in RUN
//     done                         one-cycle pulse at the terminal tick
//     irq                          sticky terminal flag
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PS_W  = DEF_PS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [PS_W-1:0]  cfg_prescale,
    input  logic             cfg_autoreload,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    // Same layout as cfg_t, sized by this instance's parameters.
    typedef struct packed {
        logic [WIDTH-1:0] limit;
        logic [PS_W-1:0]  prescale;
        logic             autoreload;
    } lcfg_t;

    state_e           r_state, w_state_nxt;
    lcfg_t            r_cfg, w_cfg_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic             r_busy;
    logic             r_done, w_done_nxt;
    logic             r_irq, w_irq_nxt;

    logic             w_tick;
    logic             w_ps_clr;
    logic             w_ps_en;
    logic             w_at_limit;

    assign cfg_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_at_limit = (r_count == r_cfg.limit);

    // Prescaler restarts from 0 on any accepted start and on abort.
    assign w_ps_clr = abort || (start && (r_state != ST_RUN));
    assign w_ps_en  = (r_state == ST_RUN) && !pause;

    counter_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_ps_clr),
        .en   (w_ps_en),
        .div  (r_cfg.prescale),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_irq_nxt   = r_irq;
        w_cfg_nxt   = r_cfg;

        // Config is latched whenever ready, including during an abort cycle.
        if (cfg_valid && cfg_ready) begin
            w_cfg_nxt = '{limit: cfg_limit, prescale: cfg_prescale,
                          autoreload: cfg_autoreload};
        end

        if (irq_clr) begin
            w_irq_nxt = 1'b0;
        end

        if (abort) begin
            // Abort overrides a same-cycle start or terminal tick.
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                        w_count_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        if (w_at_limit) begin
                            w_done_nxt = 1'b1;
                            w_irq_nxt  = 1'b1;   // set beats irq_clr
                            if (r_cfg.autoreload) begin
                                w_count_nxt = '0;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_cfg   <= w_cfg_nxt;
            r_count <= w_count_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= w_done_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign irq   = r_irq;

endmodule
